// File: rtl/piece_lock_writer.sv
// Commits a captured piece grid into the registered fixed board.
// Define LINE_CLEAR_EN to add the bottom-up full-row clear scan between merge and completion.
module piece_lock_writer #(
    parameter int FIXED_STATE_WIDTH  = 10,
    parameter int FIXED_STATE_HEIGHT = 20,
    parameter int GRID               = 4
) (
    input  logic                                                    clk,
    input  logic                                                    reset,
    input  logic                                                    lock_req,
    input  logic [GRID-1:0][GRID-1:0]                               active_piece_grid_piece,
    input  logic [$clog2(FIXED_STATE_WIDTH)-1:0]                    piece_x,
    input  logic [$clog2(FIXED_STATE_HEIGHT)-1:0]                   piece_y,
    output logic [FIXED_STATE_WIDTH-1:0][FIXED_STATE_HEIGHT-1:0]    GAME_fixed_state_screen,
    output logic                                                    busy,
    output logic                                                    lock_done,
    output logic [2:0]                                              lines_cleared,
    output logic                                                    top_out
);

    localparam int W  = FIXED_STATE_WIDTH;
    localparam int H  = FIXED_STATE_HEIGHT;
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MERGE = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic [GRID-1:0][GRID-1:0]   r_grid;
    logic [XW-1:0]               r_x;
    logic [YW-1:0]               r_y;
    logic [W-1:0][H-1:0]         r_board;
    logic [W-1:0][H-1:0]         w_merged;
    logic [W-1:0][H-1:0]         w_board_next;
    logic [GRID-1:0][H-1:0]      w_ext;
    logic                        r_busy;
    logic                        r_lock_done;
    logic                        r_top_out;
    logic                        w_row0_next;

`ifdef LINE_CLEAR_EN
    logic [YW-1:0]               r_ptr;
    logic [YW-1:0]               w_ptr_next;
    logic [2:0]                  r_cnt;
    logic [2:0]                  w_cnt_next;
    logic [2:0]                  r_lines_cleared;
    logic                        w_row_full;
    logic [W-1:0][H-1:0]         w_shifted;

    // Full-row detect at the pointer, and the board with rows above the pointer dropped by one.
    always_comb begin
        w_row_full = 1'b1;
        w_shifted  = r_board;
        for (int c = 0; c < W; c++) begin
            w_row_full      = w_row_full & r_board[c][r_ptr];
            w_shifted[c][0] = 1'b0;
            for (int rr = 1; rr < H; rr++) begin
                if (rr <= int'(r_ptr)) begin
                    w_shifted[c][rr] = r_board[c][rr-1];
                end else begin
                    w_shifted[c][rr] = r_board[c][rr];
                end
            end
        end
    end
`endif

    // Piece placement: each grid column lands on one board column; rows past the bottom shift out.
    always_comb begin
        w_merged = r_board;
        for (int px = 0; px < GRID; px++) begin
            w_ext[px] = H'(r_grid[px]);
        end
        for (int c = 0; c < W; c++) begin
            for (int px = 0; px < GRID; px++) begin
                w_merged[c] = w_merged[c] |
                              ((int'(r_x) + px == c) ? (w_ext[px] << r_y) : {H{1'b0}});
            end
        end
    end

    // Next-state, next-board and scan bookkeeping.
    always_comb begin
        w_state_next = r_state;
        w_board_next = r_board;
`ifdef LINE_CLEAR_EN
        w_ptr_next   = r_ptr;
        w_cnt_next   = r_cnt;
`endif
        case (r_state)
            IDLE: begin
                if (lock_req) begin
                    w_state_next = MERGE;
                end else begin
                    w_state_next = IDLE;
                end
            end
            MERGE: begin
                w_board_next = w_merged;
`ifdef LINE_CLEAR_EN
                w_state_next = SCAN;
                w_ptr_next   = YW'(H - 1);
                w_cnt_next   = 3'd0;
`else
                w_state_next = DONE;
`endif
            end
            SCAN: begin
`ifdef LINE_CLEAR_EN
                if (w_row_full) begin
                    w_board_next = w_shifted;
                    if (r_cnt < 3'd4) begin
                        w_cnt_next = r_cnt + 3'd1;
                    end else begin
                        w_cnt_next = r_cnt;
                    end
                end else if (r_ptr == {YW{1'b0}}) begin
                    w_state_next = DONE;
                end else begin
                    w_ptr_next = r_ptr - YW'(1);
                end
`else
                w_state_next = IDLE;
`endif
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Top row occupancy of the board as it will stand on entering DONE.
    always_comb begin
        w_row0_next = 1'b0;
        for (int c = 0; c < W; c++) begin
            w_row0_next = w_row0_next | w_board_next[c][0];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Board, captured piece and status outputs; results land together with the lock_done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_board     <= '0;
            r_grid      <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_busy      <= 1'b0;
            r_lock_done <= 1'b0;
            r_top_out   <= 1'b0;
        end else begin
            r_board     <= w_board_next;
            r_busy      <= (w_state_next != IDLE);
            r_lock_done <= (w_state_next == DONE);
            if ((r_state == IDLE) && lock_req) begin
                r_grid <= active_piece_grid_piece;
                r_x    <= piece_x;
                r_y    <= piece_y;
            end
            if (w_state_next == DONE) begin
                r_top_out <= r_top_out | w_row0_next;
            end
        end
    end

`ifdef LINE_CLEAR_EN
    // Scan pointer, saturating line counter and the published line count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr           <= '0;
            r_cnt           <= 3'd0;
            r_lines_cleared <= 3'd0;
        end else begin
            r_ptr <= w_ptr_next;
            r_cnt <= w_cnt_next;
            if (w_state_next == DONE) begin
                r_lines_cleared <= w_cnt_next;
            end
        end
    end

    assign lines_cleared = r_lines_cleared;
`else
    assign lines_cleared = 3'd0;
`endif

    assign GAME_fixed_state_screen = r_board;
    assign busy                    = r_busy;
    assign lock_done               = r_lock_done;
    assign top_out                 = r_top_out;

endmodule

// File: doc/piece_lock_writer.md
PIECE_LOCK_WRITER -- requirements
Module: piece_lock_writer

Interface
REQ-001 SHALL have parameter FIXED_STATE_WIDTH, default 10, meaning board columns.
REQ-002 SHALL have parameter FIXED_STATE_HEIGHT, default 20, meaning board rows; bit 0 of each column is the top row.
REQ-003 SHALL have parameter GRID, default 4, meaning piece bounding-grid size.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port lock_req  input  1  request to commit the active piece to the board.
REQ-007 SHALL have port active_piece_grid_piece  input  [GRID-1:0] x GRID  piece cells; element px is grid column px, and bit r is local row r, counted top-down.
REQ-008 SHALL have port piece_x  input  $clog2(FIXED_STATE_WIDTH)  board column of grid column 0.
REQ-009 SHALL have port piece_y  input  $clog2(FIXED_STATE_HEIGHT)  board row of grid row 0.
REQ-010 SHALL have port GAME_fixed_state_screen  output  [FIXED_STATE_HEIGHT-1:0] x FIXED_STATE_WIDTH  registered fixed board.
REQ-011 SHALL have port busy  output  1  high whenever the FSM is not IDLE.
REQ-012 SHALL have port lock_done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port lines_cleared  output  3  count of rows removed by the last lock, 0..4.
REQ-014 SHALL have port top_out  output  1  sticky flag: row 0 is non-empty at completion.

Function
REQ-015 SHALL implement FSM states IDLE, MERGE, SCAN and DONE.
REQ-016 SHALL capture piece_x, piece_y and the piece grid on the clock edge where lock_req=1 in IDLE, then enter MERGE; lock_req in any other state SHALL be ignored.
REQ-017 SHALL, at the MERGE edge, OR every set piece cell (px,r) into board column piece_x+px, row piece_y+r; cells with column >= WIDTH or row >= HEIGHT SHALL be dropped, without wrap.
REQ-018 SHALL enter SCAN after MERGE with row pointer = HEIGHT-1, and clear the line counter.
REQ-019 SHALL, at each SCAN edge where the pointed row is full in all WIDTH columns: shift rows 0..ptr-1 down by one into rows 1..ptr, zero row 0, increment the line counter, and hold the pointer.
REQ-020 SHALL, at each SCAN edge where the pointed row is not full, decrement the pointer; after row 0 is processed, the FSM SHALL enter DONE.
REQ-021 SHALL assert lock_done for exactly one cycle in DONE, update lines_cleared from the counter there, and set top_out if row 0 is non-empty; it SHALL then return to IDLE.
REQ-022 SHALL have a latency of lock_done in cycle 2+HEIGHT+k after the accept edge, where k = rows cleared (22 for H=20, k=0).
REQ-023 SHALL hold lines_cleared stable between DONE cycles, and the line counter SHALL saturate at 4.
REQ-024 SHALL NOT flag a merge onto an already-filled cell; OR semantics apply.

Reset
REQ-025 SHALL, on reset=1 at a clock edge: zero the board, set the FSM to IDLE, and set busy=0, lock_done=0, lines_cleared=0 and top_out=0.
REQ-026 SHALL abort any in-progress lock on reset mid-MERGE or mid-SCAN, with no lock_done pulse.

Configuration
REQ-027 SHALL, with LINE_CLEAR_EN defined, implement SCAN per REQ-018..020.
REQ-028 SHALL, without LINE_CLEAR_EN, go from MERGE directly to DONE, tie lines_cleared to 0, and give lock_done 2 cycles after accept; top_out SHALL be unchanged.

Verification
REQ-029 SHALL cover this: empty board, vertical I piece (column 0 = 4'b1111) at x=0, y=16, lock_req -> column 0 bits 16..19 set, lines_cleared=0, lock_done at cycle 22.
REQ-030 SHALL cover this: row 19 pre-filled in columns 0..8, I piece with a single set bit in row 19 of column 9 -> row 19 cleared, rows above shifted, lines_cleared=1, lock_done at cycle 23.
REQ-031 SHALL cover this: rows 16..19 filled in columns 0..8, vertical I piece at x=9, y=16 -> board empty, lines_cleared=4, lock_done at cycle 26.
REQ-032 SHALL cover this: O piece at x=9 (grid column 1 off-board) -> only column 9 written, with no wrap into column 0.
REQ-033 SHALL cover this: reset asserted at SCAN cycle 5 -> board zero, busy=0, no lock_done; a second lock_req during busy produces no effect.
REQ-034 SHALL cover this: a piece merged into rows 0..1 with no clear -> top_out=1 after DONE, remaining 1 until reset.
